// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter:
// parity codes, FSM state encoding, baud divisor and parity helpers.
package uart_pkg;

  localparam int PAR_NONE = 32'sd0;
  localparam int PAR_ODD  = 32'sd1;
  localparam int PAR_EVEN = 32'sd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Clocks per line bit, rounded to nearest.
  function automatic int calc_div(input int freq, input int rate);
    return (freq + rate / 32'sd2) / rate;
  endfunction

  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    logic p;
    p = ^data;
    if (mode == PAR_ODD) begin
      return ~p;
    end else begin
      return p;
    end
  endfunction

endpackage

// File: rtl/uart_tx_buf_fifo.sv
// Synchronous FIFO with a registered occupancy count; pushes are refused while full,
// even when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 32'sd1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             push_s;
  logic             pop_s;

  assign push_s = push && (level_r != LW'(DEPTH));
  assign pop_s  = pop && (level_r != '0);

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1'b1);
        2'b01:   level_r <= level_r - LW'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (level_r == LW'(DEPTH));
  assign empty = (level_r == '0);
  assign level = level_r;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: words enter a FIFO on a valid/ready handshake and are
// serialised as start, data (LSB first), optional parity and stop bits.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int FREQ      = 50_000_000,
  parameter int RATE      = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 16,
  localparam int LW = $clog2(DEPTH + 32'sd1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic [LW-1:0]        o_level
);

  localparam int DIV = calc_div(FREQ, RATE);
  localparam int CW  = $clog2(STOP_BITS * DIV + 32'sd1);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 32'sd1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * DIV - 32'sd1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 32'sd1);

  tx_state_t            state_r;
  logic [CW-1:0]        cnt_r;
  logic [BW-1:0]        bit_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_r;
  logic                 tx_r;
  logic                 ready_r;
  logic                 busy_r;

  logic [DATA_BITS-1:0] head_s;
  logic                 full_s;
  logic                 empty_s;
  logic [LW-1:0]        level_s;
  logic [LW-1:0]        level_nxt_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 bit_done_s;
  logic                 stop_done_s;
  logic                 going_idle_s;

  assign push_s       = i_valid && ready_r && !full_s;
  assign bit_done_s   = (cnt_r == BIT_END);
  assign stop_done_s  = (state_r == ST_STOP) && (cnt_r == STOP_END);
  assign pop_s        = !empty_s && ((state_r == ST_IDLE) || stop_done_s);
  assign going_idle_s = empty_s && ((state_r == ST_IDLE) || stop_done_s);
  assign level_nxt_s  = level_s + LW'(push_s) - LW'(pop_s);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (i_data),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level_s)
  );

  // Frame sequencer: baud counter, shift register and registered line driver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      bit_r   <= '0;
      shift_r <= '0;
      par_r   <= 1'b0;
      tx_r    <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          bit_r <= '0;
          if (!empty_s) begin
            state_r <= ST_START;
            shift_r <= head_s;
            par_r   <= parity_bit(9'(head_s), PARITY);
            tx_r    <= 1'b0;
          end else begin
            tx_r <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_done_s) begin
            state_r <= ST_DATA;
            cnt_r   <= '0;
            tx_r    <= shift_r[0];
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        ST_DATA: begin
          if (bit_done_s) begin
            cnt_r <= '0;
            if (bit_r == LAST_BIT) begin
              bit_r <= '0;
              if (PARITY != PAR_NONE) begin
                state_r <= ST_PARITY;
                tx_r    <= par_r;
              end else begin
                state_r <= ST_STOP;
                tx_r    <= 1'b1;
              end
            end else begin
              bit_r   <= bit_r + BW'(1'b1);
              shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
              tx_r    <= shift_r[1];
            end
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        ST_PARITY: begin
          if (bit_done_s) begin
            state_r <= ST_STOP;
            cnt_r   <= '0;
            tx_r    <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        ST_STOP: begin
          if (stop_done_s) begin
            cnt_r <= '0;
            // Back-to-back frames: next start bit follows the last stop clock directly.
            if (!empty_s) begin
              state_r <= ST_START;
              shift_r <= head_s;
              par_r   <= parity_bit(9'(head_s), PARITY);
              tx_r    <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
              tx_r    <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  // Status flags registered from the next-cycle occupancy so o_ready always equals !full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      ready_r <= (level_nxt_s != LW'(DEPTH));
      busy_r  <= !(going_idle_s && (level_nxt_s == '0));
    end
  end

  assign o_tx    = tx_r;
  assign o_ready = ready_r;
  assign o_busy  = busy_r;
  assign o_level = level_s;

endmodule
